// File: rtl/systolic_pkg.sv
// Shared types for the systolic operand feeder.
package systolic_pkg;

  localparam int unsigned DATA_W = 8;

  typedef logic signed [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } feed_state_t;

endpackage

// File: rtl/feed_lane.sv
// One operand lane: a K-deep element buffer plus the registered, skewed lane output.
module feed_lane
  import systolic_pkg::*;
#(
  parameter int unsigned K     = 4,
  parameter int unsigned IdxW  = 2,
  parameter int unsigned StepW = 3,
  parameter int unsigned ColW  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [ColW-1:0]  wr_idx,
  input  data_t            wr_data,
  input  logic [IdxW-1:0]  lane_idx,
  input  logic [StepW-1:0] t,
  input  logic             hold,
  output data_t            lane_data,
  output logic             lane_valid
);

  data_t            mem_q [K];
  logic [StepW-1:0] off;
  logic             hit;
  data_t            rd_data;

  always_comb begin
    off     = t - StepW'(lane_idx);
    hit     = !hold && (t >= StepW'(lane_idx)) && (off < StepW'(K));
    rd_data = mem_q[off[ColW-1:0]];
    // A write landing on the same edge as the first read must be seen by that read.
    if (wr_en && (wr_idx == off[ColW-1:0])) begin
      rd_data = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < K; k++) begin
        mem_q[k] <= '0;
      end
      lane_data  <= '0;
      lane_valid <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_idx] <= wr_data;
      end
      lane_data  <= hit ? rd_data : '0;
      lane_valid <= hit;
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder: buffers A (N x K) and B (K x N), then streams them diagonally skewed
// into the row and column lanes of the PE array edge.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned K = 4,
  localparam int unsigned RowW  = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned ColW  = (K > 1) ? $clog2(K) : 1,
  localparam int unsigned StepW = $clog2(K + N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic                wr_sel,
  input  logic [RowW-1:0]     wr_row,
  input  logic [ColW-1:0]     wr_col,
  input  data_t               wr_data,
  input  logic                start,
  input  logic                hold,
  output logic [N*DATA_W-1:0] a_out,
  output logic [N-1:0]        a_valid,
  output logic [N*DATA_W-1:0] b_out,
  output logic [N-1:0]        b_valid,
  output logic                busy,
  output logic                done,
  output logic                wr_err
);

  localparam logic [StepW-1:0] LastT = StepW'(K + N - 2);

  feed_state_t      state_q, state_d;
  logic [StepW-1:0] t_q, t_d;
  logic             emit;
  logic             col_ok;
  logic             wr_ok;
  logic             wr_err_d;

  assign col_ok = 32'(wr_col) < K;

  // t_q is the step currently on the lanes; t_d is the step the lanes register next.
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    emit     = 1'b0;
    wr_ok    = 1'b0;
    wr_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        wr_ok    = wr_en && col_ok;
        wr_err_d = wr_en && !col_ok;
        if (start) begin
          state_d = STREAM;
          t_d     = '0;
          emit    = 1'b1;
        end
      end
      STREAM: begin
        wr_err_d = wr_en || start;
        if (!hold) begin
          if (t_q == LastT) begin
            state_d = DONE;
            t_d     = '0;
          end else begin
            t_d  = t_q + 1'b1;
            emit = 1'b1;
          end
        end
      end
      DONE: begin
        wr_err_d = wr_en || start;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      busy    <= (state_d == STREAM);
      done    <= (state_d == DONE);
      wr_err  <= wr_err_d;
    end
  end

  data_t a_lane [N];
  data_t b_lane [N];

  for (genvar i = 0; i < N; i++) begin : g_lane
    feed_lane #(
      .K     (K),
      .IdxW  (RowW),
      .StepW (StepW),
      .ColW  (ColW)
    ) u_a_lane (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_ok && !wr_sel && (wr_row == RowW'(i))),
      .wr_idx     (wr_col),
      .wr_data    (wr_data),
      .lane_idx   (RowW'(i)),
      .t          (t_d),
      .hold       (!emit),
      .lane_data  (a_lane[i]),
      .lane_valid (a_valid[i])
    );

    // B lanes are addressed by column j; wr_col selects the row k within the column.
    feed_lane #(
      .K     (K),
      .IdxW  (RowW),
      .StepW (StepW),
      .ColW  (ColW)
    ) u_b_lane (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_ok && wr_sel && (wr_row == RowW'(i))),
      .wr_idx     (wr_col),
      .wr_data    (wr_data),
      .lane_idx   (RowW'(i)),
      .t          (t_d),
      .hold       (!emit),
      .lane_data  (b_lane[i]),
      .lane_valid (b_valid[i])
    );

    assign a_out[i*DATA_W +: DATA_W] = a_lane[i];
    assign b_out[i*DATA_W +: DATA_W] = b_lane[i];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: table of stream scenarios, randomized streams and a reset abort,
// all checked cycle by cycle against a matrix-level reference model.
module tb_systolic_feeder;

  localparam int N  = 4;
  localparam int K  = 4;
  localparam int DW = 8;
  localparam int VW = 2 * N + 2 * N * DW + 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic          wr_sel = 1'b0;
  logic [1:0]    wr_row = '0;
  logic [1:0]    wr_col = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic [N*DW-1:0] a_out, b_out;
  logic [N-1:0]    a_valid, b_valid;
  logic            busy, done, wr_err;

  systolic_feeder #(.N(N), .K(K)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .start   (start),
    .hold    (hold),
    .a_out   (a_out),
    .a_valid (a_valid),
    .b_out   (b_out),
    .b_valid (b_valid),
    .busy    (busy),
    .done    (done),
    .wr_err  (wr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [DW-1:0] am [N][K];
  logic signed [DW-1:0] bm [K][N];
  bit err_next;

  typedef struct {
    string       name;
    int          mat;
    bit          reload;
    bit          wr_first;
    logic [31:0] hold_pat;
    logic [31:0] wr_pat;
    logic [31:0] st_pat;
    int          exp_done;
  } vec_t;

  // Expected lane picture for one step of the skewed stream (step < 0: no data).
  function automatic logic [VW-1:0] model_vec(int step, bit eb, bit ed, bit ee);
    logic [N-1:0]    va = '0;
    logic [N-1:0]    vb = '0;
    logic [N*DW-1:0] da = '0;
    logic [N*DW-1:0] db = '0;
    for (int i = 0; i < N; i++) begin
      if (step >= i && step < i + K) begin
        va[i] = 1'b1;
        vb[i] = 1'b1;
        da[i*DW +: DW] = am[i][step-i];
        db[i*DW +: DW] = bm[step-i][i];
      end
    end
    return {va, da, vb, db, eb, ed, ee};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {a_valid, a_out, b_valid, b_out, busy, done, wr_err};
  endfunction

  task automatic expect_bits(input string name, input int c, input logic [VW-1:0] got,
                             input logic [VW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, got, exp);
    end
  endtask

  task automatic check(input string name, input int c, input int step, input bit eb,
                       input bit ed);
    expect_bits(name, c, dut_vec(), model_vec(step, eb, ed, err_next));
  endtask

  // mat: 0 identity, 1 random with signed row 1, 2 random, 3 all-zero (no writes).
  task automatic load(input int mat);
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < K; k++) begin
        case (mat)
          0: begin
            am[i][k] = (i == k) ? 8'sd1 : 8'sd0;
            bm[k][i] = (i == k) ? 8'sd1 : 8'sd0;
          end
          3: begin
            am[i][k] = '0;
            bm[k][i] = '0;
          end
          default: begin
            am[i][k] = 8'($urandom);
            bm[k][i] = 8'($urandom);
          end
        endcase
      end
    end
    if (mat == 1) begin
      am[1][0] = 8'sh80;
      am[1][1] = 8'sh7F;
      am[1][2] = 8'shFF;
      am[1][3] = 8'sh00;
    end
    if (mat != 3) begin
      for (int sel = 0; sel < 2; sel++) begin
        for (int r = 0; r < N; r++) begin
          for (int k = 0; k < K; k++) begin
            @(negedge clk);
            start   = 1'b0;
            hold    = 1'b0;
            wr_en   = 1'b1;
            wr_sel  = sel[0];
            wr_row  = 2'(r);
            wr_col  = 2'(k);
            wr_data = (sel == 1) ? bm[k][r] : am[r][k];
          end
        end
      end
    end
    @(negedge clk);
    wr_en    = 1'b0;
    start    = 1'b0;
    hold     = 1'b0;
    err_next = 1'b0;
  endtask

  // Cycle 0 samples start; the model emits steps in order, a bubble for each sampled hold,
  // and one done cycle after the last step.
  task automatic run_stream(input vec_t v);
    int emitted;
    int slot;
    int mode;
    @(negedge clk);
    check(v.name, 0, -1, 1'b0, 1'b0);
    start = 1'b1;
    hold  = v.hold_pat[0];
    wr_en = 1'b0;
    if (v.wr_first) begin
      wr_en    = 1'b1;
      wr_sel   = 1'b0;
      wr_row   = 2'd0;
      wr_col   = 2'd0;
      wr_data  = 8'h5A;
      am[0][0] = 8'sh5A;
    end
    err_next = 1'b0;
    slot     = 0;
    emitted  = 1;
    mode     = 1;
    for (int c = 1; c < 32; c++) begin
      @(negedge clk);
      check(v.name, c, (mode == 1) ? slot : -1, mode == 1, mode == 2);
      if (c == v.exp_done) begin
        n_checks++;
        if (done !== 1'b1) begin
          n_fail++;
          $display("FAIL %s done_cycle: done=%b at cycle %0d, required 1", v.name, done, c);
        end
      end
      start    = v.st_pat[c];
      hold     = v.hold_pat[c];
      wr_en    = v.wr_pat[c];
      wr_sel   = c[0];
      wr_row   = 2'(c);
      wr_col   = 2'(c + 1);
      wr_data  = 8'h33;
      err_next = v.wr_pat[c] | v.st_pat[c];
      if (mode == 2) break;
      if (hold) begin
        slot = -1;
      end else if (emitted == K + N - 1) begin
        mode = 2;
      end else begin
        slot = emitted;
        emitted++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, n_checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [7];
    vec_t rv;

    vecs[0] = '{"identity",      0, 1'b1, 1'b0, 32'h0,  32'h0,   32'h0,   8};
    vecs[1] = '{"signed",        1, 1'b1, 1'b0, 32'h0,  32'h0,   32'h0,   8};
    vecs[2] = '{"hold",          2, 1'b1, 1'b0, 32'h30, 32'h0,   32'h0,   10};
    vecs[3] = '{"illegal",       2, 1'b1, 1'b0, 32'h0,  32'h104, 32'h28,  8};
    vecs[4] = '{"b2b_first",     2, 1'b0, 1'b0, 32'h0,  32'h0,   32'h1FE, 8};
    vecs[5] = '{"b2b_second",    2, 1'b0, 1'b0, 32'h0,  32'h0,   32'h0,   8};
    vecs[6] = '{"wr_with_start", 2, 1'b1, 1'b1, 32'h0,  32'h0,   32'h0,   8};

    @(negedge clk);
    expect_bits("reset_state", 0, dut_vec(), '0);
    @(negedge clk);
    reset = 1'b1;

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].reload) load(vecs[v].mat);
      run_stream(vecs[v]);
    end

    for (int r = 0; r < 4; r++) begin
      rv.name     = "random";
      rv.mat      = 2;
      rv.reload   = 1'b1;
      rv.wr_first = 1'b0;
      rv.hold_pat = $urandom & $urandom & 32'h3FE;
      rv.wr_pat   = $urandom & $urandom & $urandom & 32'h1FE;
      rv.st_pat   = $urandom & $urandom & $urandom & 32'h0FE;
      rv.exp_done = -1;
      load(rv.mat);
      run_stream(rv);
    end

    // Abort a stream with reset while step 2 is on the lanes.
    load(2);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expect_bits("reset_pre", 3, dut_vec(), model_vec(2, 1'b1, 1'b0, 1'b0));
    reset = 1'b0;
    #1;
    expect_bits("reset_async", 3, dut_vec(), '0);
    @(posedge clk);
    #1;
    expect_bits("reset_edge", 4, dut_vec(), '0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      expect_bits("reset_quiet", c, dut_vec(), '0);
    end

    // Buffers must have been cleared by the reset.
    load(3);
    rv.name     = "cleared";
    rv.mat      = 3;
    rv.reload   = 1'b0;
    rv.wr_first = 1'b0;
    rv.hold_pat = 32'h0;
    rv.wr_pat   = 32'h0;
    rv.st_pat   = 32'h0;
    rv.exp_done = 8;
    run_stream(rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
